// File: rtl/jtopl_eg_ctrl.sv
// Envelope controller for the OPL envelope generator: recirculating per-slot ADSR
// phase, attenuation, key latch and counter bit, plus the global envelope counter.
module jtopl_eg_ctrl #(
    parameter int NSLOTS = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        zero,
    input  logic        keyon,
    input  logic        en_sus,
    input  logic [3:0]  arate,
    input  logic [3:0]  drate,
    input  logic [3:0]  rrate,
    input  logic [3:0]  sl,
    input  logic [5:0]  rate,
    input  logic        step,
    input  logic        sum_up,
    input  logic        cnt_lsb,
    output logic        attack,
    output logic [4:0]  base_rate,
    output logic [14:0] eg_cnt,
    output logic        cnt_in,
    output logic [8:0]  eg_out
);

    typedef enum logic [1:0] {
        ST_ATTACK  = 2'd0,
        ST_DECAY   = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } egState_e;

    egState_e    state_q [NSLOTS];
    logic [8:0]  eg_q    [NSLOTS];
    logic        konl_q  [NSLOTS];
    logic        cntl_q  [NSLOTS];
    logic [14:0] egCnt_q;
    logic [8:0]  egOut_q;

    egState_e    state_d;
    logic [8:0]  eg_d;

    egState_e    headState;
    logic [8:0]  headEg;
    logic        headKon;
    logic        stepEn;
    logic [8:0]  egInc;
    logic [9:0]  attDiff;
    logic [8:0]  egAtt;
    logic [1:0]  unusedRateLsbs;

    assign headState      = state_q[0];
    assign headEg         = eg_q[0];
    assign headKon        = konl_q[0];
    assign stepEn         = step & sum_up;
    assign unusedRateLsbs = rate[1:0];

    assign egInc   = (headEg == 9'h1FF) ? headEg : headEg + 9'd1;
    assign attDiff = {1'b0, headEg} - {4'd0, headEg[8:3]} - 10'd1;
    assign egAtt   = attDiff[9] ? 9'd0 : attDiff[8:0];

    assign attack = (headState == ST_ATTACK);
    assign cnt_in = cntl_q[0];
    assign eg_cnt = egCnt_q;
    assign eg_out = egOut_q;

    always_comb begin
        base_rate = 5'd0;
        case (headState)
            ST_ATTACK:  base_rate = {arate, 1'b0};
            ST_DECAY:   base_rate = {drate, 1'b0};
            ST_SUSTAIN: base_rate = en_sus ? 5'd0 : {rrate, 1'b0};
            default:    base_rate = {rrate, 1'b0};
        endcase
    end

    // Key edges override the level update; the DECAY exit looks at the already-updated level.
    always_comb begin
        state_d = headState;
        eg_d    = headEg;
        if (keyon && !headKon) begin
            state_d = ST_ATTACK;
        end else if (!keyon && headKon) begin
            state_d = ST_RELEASE;
        end else begin
            case (headState)
                ST_ATTACK: begin
                    if (stepEn) begin
                        eg_d = (rate[5:2] == 4'hF) ? 9'd0 : egAtt;
                    end
                    if (headEg == 9'd0) begin
                        state_d = ST_DECAY;
                    end
                end
                ST_DECAY: begin
                    if (stepEn) begin
                        eg_d = egInc;
                    end
                    if (eg_d[8:4] >= {1'b0, sl}) begin
                        state_d = ST_SUSTAIN;
                    end
                end
                default: begin
                    if (stepEn) begin
                        eg_d = egInc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOTS; i++) begin
                state_q[i] <= ST_RELEASE;
                eg_q[i]    <= 9'h1FF;
                konl_q[i]  <= 1'b0;
                cntl_q[i]  <= 1'b0;
            end
            egCnt_q <= 15'd0;
            egOut_q <= 9'h1FF;
        end else if (cen) begin
            for (int i = 0; i < NSLOTS - 1; i++) begin
                state_q[i] <= state_q[i+1];
                eg_q[i]    <= eg_q[i+1];
                konl_q[i]  <= konl_q[i+1];
                cntl_q[i]  <= cntl_q[i+1];
            end
            state_q[NSLOTS-1] <= state_d;
            eg_q[NSLOTS-1]    <= eg_d;
            konl_q[NSLOTS-1]  <= keyon;
            cntl_q[NSLOTS-1]  <= cnt_lsb;
            egOut_q           <= eg_d;
            if (zero) begin
                egCnt_q <= egCnt_q + 15'd1;
            end
        end
    end

endmodule

// File: tb/tb_jtopl_eg_ctrl.sv
// Self-checking bench for jtopl_eg_ctrl: directed vector table, hand-written corner
// sequences and randomized frames against a slot-indexed behavioural model.
module tb_jtopl_eg_ctrl;

    localparam int NS = 18;

    logic        clk = 1'b0;
    logic        rst_n, cen, zero, keyon, en_sus;
    logic [3:0]  arate, drate, rrate, sl;
    logic [5:0]  rate;
    logic        step, sum_up, cnt_lsb;
    logic        attack, cnt_in;
    logic [4:0]  base_rate;
    logic [14:0] eg_cnt;
    logic [8:0]  eg_out;

    jtopl_eg_ctrl #(.NSLOTS(NS)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .keyon(keyon),
        .en_sus(en_sus), .arate(arate), .drate(drate), .rrate(rrate), .sl(sl),
        .rate(rate), .step(step), .sum_up(sum_up), .cnt_lsb(cnt_lsb),
        .attack(attack), .base_rate(base_rate), .eg_cnt(eg_cnt),
        .cnt_in(cnt_in), .eg_out(eg_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       keyon, enSus;
        bit [3:0] arate, drate, rrate, sl;
        bit [5:0] rate;
        bit       step, sumUp, cntLsb;
    } stim_t;

    typedef struct {
        stim_t    in;
        bit       expAttack;
        bit [4:0] expBase;
        bit [8:0] expEgOut;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Model indexed by slot number: 0=ATTACK 1=DECAY 2=SUSTAIN 3=RELEASE
    int mState[NS], mEg[NS], mKon[NS], mCnt[NS];
    int mPtr, mEgCnt, mEgOut;

    int tgtAttack, tgtBase, tgtEgOut;
    stim_t idle;
    vec_t  tbl[14];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h (slot %0d)", name, actual, expected, mPtr);
        end
    endtask

    function automatic int modelBase(input stim_t s);
        case (mState[mPtr])
            0:       return s.arate * 2;
            1:       return s.drate * 2;
            2:       return s.enSus ? 0 : s.rrate * 2;
            default: return s.rrate * 2;
        endcase
    endfunction

    task automatic applyStimulus(input stim_t s, input bit forceZero);
        int st, eg, nst, neg;
        @(negedge clk);
        cen = 1'b1; zero = forceZero || (mPtr == 0);
        keyon = s.keyon; en_sus = s.enSus; arate = s.arate; drate = s.drate;
        rrate = s.rrate; sl = s.sl; rate = s.rate; step = s.step;
        sum_up = s.sumUp; cnt_lsb = s.cntLsb;
        #1;
        checkOutput("attack", attack, mState[mPtr] == 0);
        checkOutput("base_rate", base_rate, modelBase(s));
        checkOutput("cnt_in", cnt_in, mCnt[mPtr]);
        checkOutput("eg_cnt", eg_cnt, mEgCnt);
        tgtAttack = attack;
        tgtBase   = base_rate;
        st = mState[mPtr]; eg = mEg[mPtr]; nst = st; neg = eg;
        if (s.keyon && mKon[mPtr] == 0) nst = 0;
        else if (!s.keyon && mKon[mPtr] == 1) nst = 3;
        else if (st == 0) begin
            if (s.step && s.sumUp) begin
                neg = (s.rate >= 60) ? 0 : eg - eg / 8 - 1;
                if (neg < 0) neg = 0;
            end
            if (eg == 0) nst = 1;
        end else begin
            if (s.step && s.sumUp) neg = (eg + 1 > 511) ? 511 : eg + 1;
            if (st == 1 && neg / 16 >= s.sl) nst = 2;
        end
        @(posedge clk);
        #1;
        mState[mPtr] = nst; mEg[mPtr] = neg;
        mKon[mPtr] = s.keyon; mCnt[mPtr] = s.cntLsb;
        mEgOut = neg;
        if (zero) mEgCnt = (mEgCnt + 1) % 32768;
        mPtr = (mPtr + 1) % NS;
        checkOutput("eg_out", eg_out, mEgOut);
        tgtEgOut = eg_out;
    endtask

    task automatic runFrame(input int tgt, input stim_t ts);
        int a, b, e;
        a = 0; b = 0; e = 0;
        for (int s = 0; s < NS; s++) begin
            if (s == tgt) begin
                applyStimulus(ts, 1'b0);
                a = tgtAttack; b = tgtBase; e = tgtEgOut;
            end else begin
                applyStimulus(idle, 1'b0);
            end
        end
        tgtAttack = a; tgtBase = b; tgtEgOut = e;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n = 1'b0; cen = 1'b1; zero = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; cen = 1'b0; zero = 1'b0;
        for (int i = 0; i < NS; i++) begin
            mState[i] = 3; mEg[i] = 511; mKon[i] = 0; mCnt[i] = 0;
        end
        mPtr = 0; mEgCnt = 0; mEgOut = 511;
    endtask

    function automatic vec_t mk(input bit k, input bit e, input int a, input int d,
                                input int r, input int l, input int rt, input bit st,
                                input bit su, input bit ea, input int eb, input int eo);
        vec_t v;
        v.in.keyon = k; v.in.enSus = e; v.in.arate = 4'(a); v.in.drate = 4'(d);
        v.in.rrate = 4'(r); v.in.sl = 4'(l); v.in.rate = 6'(rt); v.in.step = st;
        v.in.sumUp = su; v.in.cntLsb = k;
        v.expAttack = ea; v.expBase = 5'(eb); v.expEgOut = 9'(eo);
        return v;
    endfunction

    initial begin
        stim_t s;
        bit    keys[NS];
        int    holdOut, holdCnt;

        idle = '{default: 0};
        tbl[0]  = mk(1, 1, 15, 5, 7, 4, 60, 1, 1, 0, 14, 'h1FF);
        tbl[1]  = mk(1, 1, 15, 5, 7, 4, 60, 1, 1, 1, 30, 'h000);
        tbl[2]  = mk(1, 1, 15, 5, 7, 4, 60, 0, 0, 1, 30, 'h000);
        tbl[3]  = mk(1, 1, 15, 5, 7, 4, 60, 1, 1, 0, 10, 'h001);
        tbl[4]  = mk(0, 1, 15, 5, 7, 4,  0, 1, 1, 0, 10, 'h001);
        tbl[5]  = mk(0, 1, 15, 5, 7, 4,  0, 1, 1, 0, 14, 'h002);
        tbl[6]  = mk(1, 1,  3, 5, 7, 4, 12, 1, 1, 0, 14, 'h002);
        tbl[7]  = mk(1, 1,  3, 5, 7, 4, 12, 1, 1, 1,  6, 'h001);
        tbl[8]  = mk(1, 1,  3, 5, 7, 4, 12, 1, 1, 1,  6, 'h000);
        tbl[9]  = mk(1, 1,  3, 5, 7, 4, 12, 1, 1, 1,  6, 'h000);
        tbl[10] = mk(1, 1,  3, 5, 7, 0, 12, 1, 1, 0, 10, 'h001);
        tbl[11] = mk(1, 1,  3, 5, 7, 0, 12, 1, 0, 0,  0, 'h001);
        tbl[12] = mk(1, 0,  3, 5, 7, 0, 12, 1, 1, 0, 14, 'h002);
        tbl[13] = mk(1, 0,  3, 5, 7, 0, 12, 1, 1, 0, 14, 'h003);

        rst_n = 1'b1; cen = 1'b0; zero = 1'b0; keyon = 1'b0; en_sus = 1'b0;
        arate = '0; drate = '0; rrate = '0; sl = '0; rate = '0;
        step = 1'b0; sum_up = 1'b0; cnt_lsb = 1'b0;

        resetDut();
        #1;
        checkOutput("reset_eg_out", eg_out, 'h1FF);
        checkOutput("reset_attack", attack, 0);
        checkOutput("reset_eg_cnt", eg_cnt, 0);
        checkOutput("reset_cnt_in", cnt_in, 0);

        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < NS; i++) begin
                applyStimulus(idle, 1'b0);
                checkOutput("idle_level", eg_out, 'h1FF);
            end
        end
        checkOutput("idle_eg_cnt", eg_cnt, 2);
        checkOutput("idle_attack", attack, 0);

        // Slot 3 walks through attack, decay, release and sustain
        for (int v = 0; v < 14; v++) begin
            runFrame(3, tbl[v].in);
            checkOutput($sformatf("tbl%0d_attack", v), tgtAttack, tbl[v].expAttack);
            checkOutput($sformatf("tbl%0d_base", v), tgtBase, tbl[v].expBase);
            checkOutput($sformatf("tbl%0d_eg_out", v), tgtEgOut, tbl[v].expEgOut);
        end

        // Slot 5 release saturates at 0x1FF
        s = idle; s.step = 1; s.sumUp = 1; s.rrate = 7;
        for (int f = 0; f < 2; f++) begin
            runFrame(5, s);
            checkOutput("sat_eg_out", tgtEgOut, 'h1FF);
            checkOutput("sat_base", tgtBase, 14);
        end

        // Key-off in the middle of an attack keeps the level and enters release
        s = idle; s.keyon = 1;
        runFrame(7, s);
        s.arate = 3; s.rate = 12; s.step = 1; s.sumUp = 1;
        runFrame(7, s);
        checkOutput("att_first_step", tgtEgOut, 'h1BF);
        s.keyon = 0;
        runFrame(7, s);
        checkOutput("koff_attack_flag", tgtAttack, 1);
        checkOutput("koff_eg_out", tgtEgOut, 'h1BF);
        s = idle; s.rrate = 9;
        runFrame(7, s);
        checkOutput("koff_base", tgtBase, 18);
        checkOutput("koff_attack", tgtAttack, 0);

        // Clock enable held low mid-frame freezes everything
        for (int i = 0; i < 7; i++) applyStimulus(idle, 1'b0);
        holdOut = eg_out; holdCnt = eg_cnt;
        @(negedge clk);
        cen = 1'b0; zero = 1'b1;
        for (int c = 0; c < 10; c++) begin
            keyon = 1'($urandom); step = 1'($urandom); sum_up = 1'($urandom);
            rate = 6'($urandom); cnt_lsb = 1'($urandom);
            @(posedge clk);
            #1;
            checkOutput("hold_eg_out", eg_out, mEgOut);
            checkOutput("hold_eg_cnt", eg_cnt, mEgCnt);
            checkOutput("hold_attack", attack, mState[mPtr] == 0);
            checkOutput("hold_cnt_in", cnt_in, mCnt[mPtr]);
        end
        checkOutput("hold_eg_out_start", eg_out, holdOut);
        checkOutput("hold_eg_cnt_start", eg_cnt, holdCnt);
        for (int i = 7; i < NS; i++) applyStimulus(idle, 1'b0);

        // Randomized frames against the model
        for (int i = 0; i < NS; i++) keys[i] = 0;
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < NS; i++) begin
                if ($urandom_range(0, 7) == 0) keys[i] = !keys[i];
                s.keyon  = keys[i];
                s.enSus  = 1'($urandom);
                s.arate  = 4'($urandom);
                s.drate  = 4'($urandom);
                s.rrate  = 4'($urandom);
                s.sl     = 4'($urandom);
                s.rate   = ($urandom_range(0, 3) == 0) ? 6'(60 + $urandom_range(0, 3))
                                                        : 6'($urandom_range(0, 59));
                s.step   = ($urandom_range(0, 3) != 0);
                s.sumUp  = ($urandom_range(0, 3) != 0);
                s.cntLsb = 1'($urandom);
                applyStimulus(s, 1'b0);
            end
        end

        // Drive zero on every enable to bring the envelope counter round to its wrap
        while (mEgCnt != 32767) applyStimulus(idle, 1'b1);
        checkOutput("eg_cnt_max", eg_cnt, 'h7FFF);
        applyStimulus(idle, 1'b1);
        checkOutput("eg_cnt_wrap", eg_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
